// File: rtl/micron_sram_model.sv
// Device-side responder for the MT45W8 synchronous burst interface: latches an
// address on ADV, holds mwait for the access latency, then streams a word per clock.
// Define MICRON_MODEL_CRE_EN to add the configuration register reached through mcre.
module micron_sram_model #(
    parameter int A_WIDTH = 16,
    parameter int D_WIDTH = 16,
    parameter int MEM_AW  = 8,
    parameter int LATENCY = 4
) (
    input  logic               clk50MHz,
    input  logic               rst,
    input  logic [A_WIDTH-1:0] maddr,
    input  logic               madv_L,
    input  logic               mce_L,
    input  logic               mwe_L,
    input  logic               moe_L,
    input  logic               mcre,
    input  logic [D_WIDTH-1:0] mdata_in,
    output logic [D_WIDTH-1:0] mdata_out,
    output logic               mdata_oe,
    output logic               mwait
);

    localparam int DEPTH = 1 << MEM_AW;
    localparam int CW    = $clog2(LATENCY + 8) + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LAT  = 2'd1,
        S_RD   = 2'd2,
        S_WR   = 2'd3
    } state_t;

    state_t              r_state;
    logic [MEM_AW-1:0]   r_addr;
    logic [CW-1:0]       r_cnt;
    logic                r_write;
    logic [D_WIDTH-1:0]  r_mem [DEPTH];

    logic                w_adv;
    logic                w_we;
    logic [MEM_AW-1:0]   w_next_addr;
    logic [CW-1:0]       w_lat_target;
    logic                w_unused;

    assign w_adv       = !mce_L && !madv_L;
    assign w_next_addr = r_addr + MEM_AW'(1);
    // A new ADV takes priority over the burst, so no array write on that edge.
    assign w_we        = (r_state == S_WR) && !mce_L && madv_L && !rst;
    assign mdata_oe    = (r_state == S_RD) && !moe_L && !mce_L;
    assign w_unused    = ^{maddr, mcre};

`ifdef MICRON_MODEL_CRE_EN
    logic [15:0] r_cfg;
    logic        r_cre;

    assign w_lat_target = (r_cfg[13:11] != 3'd0) ? CW'(r_cfg[13:11]) : CW'(LATENCY);

    always_ff @(posedge clk50MHz or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_addr    <= '0;
            r_cnt     <= '0;
            r_write   <= 1'b0;
            r_cfg     <= '0;
            r_cre     <= 1'b0;
            mwait     <= 1'b0;
            mdata_out <= '0;
        end else if (mce_L) begin
            r_state <= S_IDLE;
            mwait   <= 1'b0;
        end else if (!madv_L) begin
            if (mcre && !mwe_L) begin
                // Register write completes on the latch edge with no latency.
                r_cfg   <= maddr[15:0];
                r_state <= S_IDLE;
                mwait   <= 1'b0;
            end else begin
                r_addr  <= maddr[MEM_AW-1:0];
                r_write <= !mwe_L;
                r_cre   <= mcre;
                r_cnt   <= CW'(1);
                r_state <= S_LAT;
                mwait   <= 1'b1;
            end
        end else begin
            case (r_state)
                S_LAT: begin
                    if (r_cnt == w_lat_target) begin
                        r_state <= r_write ? S_WR : S_RD;
                        mwait   <= 1'b0;
                        if (!r_write)
                            mdata_out <= r_cre ? D_WIDTH'(r_cfg) : r_mem[r_addr];
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                S_RD: begin
                    if (r_cre) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_addr    <= w_next_addr;
                        mdata_out <= r_mem[w_next_addr];
                    end
                end
                S_WR:    r_addr <= w_next_addr;
                default: ;
            endcase
        end
    end
`else
    assign w_lat_target = CW'(LATENCY);

    always_ff @(posedge clk50MHz or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_addr    <= '0;
            r_cnt     <= '0;
            r_write   <= 1'b0;
            mwait     <= 1'b0;
            mdata_out <= '0;
        end else if (mce_L) begin
            r_state <= S_IDLE;
            mwait   <= 1'b0;
        end else if (!madv_L) begin
            r_addr  <= maddr[MEM_AW-1:0];
            r_write <= !mwe_L;
            r_cnt   <= CW'(1);
            r_state <= S_LAT;
            mwait   <= 1'b1;
        end else begin
            case (r_state)
                S_LAT: begin
                    if (r_cnt == w_lat_target) begin
                        r_state <= r_write ? S_WR : S_RD;
                        mwait   <= 1'b0;
                        if (!r_write)
                            mdata_out <= r_mem[r_addr];
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                S_RD: begin
                    r_addr    <= w_next_addr;
                    mdata_out <= r_mem[w_next_addr];
                end
                S_WR:    r_addr <= w_next_addr;
                default: ;
            endcase
        end
    end
`endif

    // The array has no reset so its contents survive a reset pulse.
    always_ff @(posedge clk50MHz) begin
        if (w_we)
            r_mem[r_addr] <= mdata_in;
    end

endmodule
